count_uart_tx: RTL and testbench

Downstream consumer of the 8-bit free-running counter. It watches the counter value and reports each new value to the Raspberry Pi over a TX-only UART. Each report is an ASCII frame of two uppercase hex digits followed by CR LF. If the counter moves while a frame is in flight, only the newest value is reported; skipped changes are counted.

---
 rtl/count_uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_count_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_uart_tx.sv
// Reports every new value of the free-running counter over a TX-only 8N1 UART
// as two uppercase hex digits followed by CR LF; changes seen mid-frame are counted.
module count_uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] count,
   output logic       tx,
   output logic       busy,
   output logic [7:0] last_sent,
   output logic [7:0] skip_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state_q, state_d;
   logic [15:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [1:0]  char_idx_q, char_idx_d;
   logic [7:0]  snap_q, snap_d;
   logic [7:0]  last_sent_q, last_sent_d;
   logic [7:0]  skip_q, skip_d;
   logic [7:0]  prev_q, prev_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;

   logic [7:0]  cur_char;
   logic [2:0]  nxt_idx;
   logic        bit_done;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'd0, nib};
      end
      return 8'h37 + {4'd0, nib};
   endfunction

   function automatic logic [7:0] frame_char(input logic [1:0] idx, input logic [7:0] val);
      case (idx)
         2'd0:    return hex_ascii(val[7:4]);
         2'd1:    return hex_ascii(val[3:0]);
         2'd2:    return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] val);
      if (val == 8'hFF) begin
         return val;
      end
      return val + 8'd1;
   endfunction

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      bit_idx_d   = bit_idx_q;
      char_idx_d  = char_idx_q;
      snap_d      = snap_q;
      last_sent_d = last_sent_q;
      skip_d      = skip_q;
      prev_d      = count;
      tx_d        = tx_q;
      busy_d      = busy_q;

      cur_char = frame_char(char_idx_q, snap_q);
      nxt_idx  = bit_idx_q + 3'd1;
      bit_done = (bit_cnt_q == BIT_LAST);

      // busy_q is still low on the edge that leaves IDLE, so that change is not a skip
      if (busy_q && (count != prev_q)) begin
         skip_d = sat_inc(skip_q);
      end

      case (state_q)
         IDLE: begin
            tx_d       = 1'b1;
            busy_d     = 1'b0;
            bit_cnt_d  = '0;
            bit_idx_d  = '0;
            char_idx_d = '0;
            if (count != last_sent_q) begin
               state_d     = START;
               snap_d      = count;
               last_sent_d = count;
               busy_d      = 1'b1;
               tx_d        = 1'b0;
            end
         end

         START: begin
            if (bit_done) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = DATA;
               tx_d      = cur_char[0];
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end

         DATA: begin
            if (bit_done) begin
               bit_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = nxt_idx;
                  tx_d      = cur_char[nxt_idx];
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end

         STOP: begin
            if (bit_done) begin
               bit_cnt_d = '0;
               if (char_idx_q == 2'd3) begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  // next start bit follows the stop bit with no idle gap
                  char_idx_d = char_idx_q + 2'd1;
                  state_d    = START;
                  tx_d       = 1'b0;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         bit_idx_q   <= '0;
         char_idx_q  <= '0;
         snap_q      <= '0;
         last_sent_q <= '0;
         skip_q      <= '0;
         prev_q      <= '0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         bit_idx_q   <= bit_idx_d;
         char_idx_q  <= char_idx_d;
         snap_q      <= snap_d;
         last_sent_q <= last_sent_d;
         skip_q      <= skip_d;
         prev_q      <= prev_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
      end
   end

   assign tx        = tx_q;
   assign busy      = busy_q;
   assign last_sent = last_sent_q;
   assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx at CLKS_PER_BIT=4: decodes each frame bit-by-bit
// and checks timing, frame content, latest-value-wins, async reset and skip saturation.
module tb_count_uart_tx;

   localparam int CPB = 4;

   logic       clk;
   logic       rst;
   logic [7:0] count;
   logic       tx;
   logic       busy;
   logic [7:0] last_sent;
   logic [7:0] skip_cnt;

   int checks   = 0;
   int failures = 0;

   count_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .count     (count),
      .tx        (tx),
      .busy      (busy),
      .last_sent (last_sent),
      .skip_cnt  (skip_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Waits (bounded) for a start bit at a falling clock edge, then decodes four characters.
   task automatic capture(output logic [31:0] frame, output int busy_len,
                          output logic end_busy, output logic framing_ok, output int wait_cyc);
      logic [7:0] ch;
      int r;
      frame      = '0;
      busy_len   = 0;
      end_busy   = 1'b1;
      framing_ok = 1'b1;
      wait_cyc   = 0;
      ch         = '0;
      while (tx !== 1'b0 && wait_cyc < 1000) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (tx !== 1'b0) begin
         framing_ok = 1'b0;
         return;
      end
      for (int t = 0; t < 40 * CPB; t++) begin
         r = t % (10 * CPB);
         if (busy === 1'b1) busy_len++;
         if (r % CPB == CPB / 2) begin
            if (r / CPB == 0) begin
               if (tx !== 1'b0) framing_ok = 1'b0;
            end else if (r / CPB == 9) begin
               if (tx !== 1'b1) framing_ok = 1'b0;
               frame = {frame[23:0], ch};
            end else begin
               ch[3'(r / CPB - 1)] = tx;
            end
         end
         @(negedge clk);
      end
      end_busy = busy;
   endtask

   task automatic test_reset();
      logic saw_activity;
      rst   = 1'b0;
      count = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (last_sent !== 8'h00) begin failures++; $display("FAIL reset_last_sent: got %h want 00", last_sent); end
      checks++;
      if (skip_cnt !== 8'h00) begin failures++; $display("FAIL reset_skip: got %h want 00", skip_cnt); end
      rst = 1'b1;
      saw_activity = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) saw_activity = 1'b1;
      end
      checks++;
      if (saw_activity !== 1'b0) begin failures++; $display("FAIL idle_hold: got activity=%b want 0", saw_activity); end
      checks++;
      if (last_sent !== 8'h00) begin failures++; $display("FAIL idle_last_sent: got %h want 00", last_sent); end
   endtask

   task automatic test_single();
      logic [31:0] f;
      int bl, w;
      logic eb, ok;
      count = 8'h05;
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL single_pre_tx: got %b want 1", tx); end
      @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin failures++; $display("FAIL single_latency_tx: got %b want 0", tx); end
      capture(f, bl, eb, ok, w);
      checks++;
      if (f !== 32'h3035_0D0A) begin failures++; $display("FAIL single_frame: got %h want 30350d0a", f); end
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL single_framing: got %b want 1", ok); end
      checks++;
      if (bl !== 160) begin failures++; $display("FAIL single_busy_len: got %0d want 160", bl); end
      checks++;
      if (eb !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b want 0", eb); end
      checks++;
      if (last_sent !== 8'h05) begin failures++; $display("FAIL single_last_sent: got %h want 05", last_sent); end
   endtask

   task automatic test_wrap();
      logic [31:0] f;
      int bl, w;
      logic eb, ok;
      count = 8'h0F;
      capture(f, bl, eb, ok, w);
      checks++;
      if (f !== 32'h3046_0D0A) begin failures++; $display("FAIL wrap_0f_frame: got %h want 30460d0a", f); end
      count = 8'h00;
      capture(f, bl, eb, ok, w);
      checks++;
      if (f !== 32'h3030_0D0A) begin failures++; $display("FAIL wrap_00_frame: got %h want 30300d0a", f); end
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL wrap_framing: got %b want 1", ok); end
      checks++;
      if (last_sent !== 8'h00) begin failures++; $display("FAIL wrap_last_sent: got %h want 00", last_sent); end
      checks++;
      if (skip_cnt !== 8'h00) begin failures++; $display("FAIL wrap_skip: got %h want 00", skip_cnt); end
   endtask

   task automatic test_latest_wins();
      logic [31:0] f;
      int bl, w;
      logic eb, ok;
      count = 8'h01;
      @(negedge clk);
      fork
         capture(f, bl, eb, ok, w);
         begin
            repeat (10) @(negedge clk);
            count = 8'h02;
            repeat (10) @(negedge clk);
            count = 8'h03;
            repeat (10) @(negedge clk);
            count = 8'h04;
         end
      join
      checks++;
      if (f !== 32'h3031_0D0A) begin failures++; $display("FAIL latest_first_frame: got %h want 30310d0a", f); end
      capture(f, bl, eb, ok, w);
      checks++;
      if (w !== 1) begin failures++; $display("FAIL latest_idle_gap: got %0d want 1", w); end
      checks++;
      if (f !== 32'h3034_0D0A) begin failures++; $display("FAIL latest_second_frame: got %h want 30340d0a", f); end
      checks++;
      if (skip_cnt !== 8'h03) begin failures++; $display("FAIL latest_skip: got %h want 03", skip_cnt); end
      checks++;
      if (last_sent !== 8'h04) begin failures++; $display("FAIL latest_last_sent: got %h want 04", last_sent); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] f;
      int bl, w;
      logic eb, ok;
      count = 8'h07;
      @(negedge clk);
      repeat (57) @(negedge clk);
      checks++;
      if (tx !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL midrst_pre: got tx=%b busy=%b want tx=0 busy=1", tx, busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL midrst_async_tx: got %b want 1", tx); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL midrst_async_busy: got %b want 0", busy); end
      checks++;
      if (last_sent !== 8'h00 || skip_cnt !== 8'h00) begin
         failures++; $display("FAIL midrst_regs: got last=%h skip=%h want 00 00", last_sent, skip_cnt);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      capture(f, bl, eb, ok, w);
      checks++;
      if (f !== 32'h3037_0D0A) begin failures++; $display("FAIL midrst_frame: got %h want 30370d0a", f); end
      checks++;
      if (bl !== 160) begin failures++; $display("FAIL midrst_busy_len: got %0d want 160", bl); end
      checks++;
      if (last_sent !== 8'h07) begin failures++; $display("FAIL midrst_last_sent: got %h want 07", last_sent); end
   endtask

   task automatic test_skip_saturate();
      count = 8'h08;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 160) begin
            checks++;
            if (skip_cnt !== 8'hA0) begin failures++; $display("FAIL skip_partial: got %h want a0", skip_cnt); end
         end
         count = (i % 2 == 1) ? 8'h0A : 8'h09;
      end
      repeat (400) @(negedge clk);
      checks++;
      if (skip_cnt !== 8'hFF) begin failures++; $display("FAIL skip_saturated: got %h want ff", skip_cnt); end
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         failures++; $display("FAIL skip_final_idle: got busy=%b tx=%b want 0 1", busy, tx);
      end
      checks++;
      if (last_sent !== 8'h0A) begin failures++; $display("FAIL skip_last_sent: got %h want 0a", last_sent); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_latest_wins();
      test_reset_mid_frame();
      test_skip_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
